// File: rtl/song_sequencer.sv
// song_sequencer: walks a song ROM of {note, duration} words and feeds note_player.
// Each nonzero word produces one load_new_note strobe; the sequencer then waits for
// done_with_note before fetching the next word. The all-zero word ends the song.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   play              level: 1 = run/advance, 0 = pause
//   restart           1-cycle pulse: back to address 0 and IDLE
//   rom_addr          song ROM address (registered)
//   rom_data          ROM word {note[11:6], duration[5:0]}, valid 1 cycle after rom_addr
//   note_to_load      note for note_player (registered)
//   duration_to_load  duration for note_player (registered)
//   load_new_note     1-cycle load strobe to note_player
//   done_with_note    note_player finished the current note
//   play_enable       registered copy of play, forced 0 outside the run states
//   song_done         high while in DONE
module song_sequencer #(
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  restart,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [11:0]           rom_data,
    output logic [5:0]            note_to_load,
    output logic [5:0]            duration_to_load,
    output logic                  load_new_note,
    input  logic                  done_with_note,
    output logic                  play_enable,
    output logic                  song_done
);

    localparam int unsigned FIELD_W = 6;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_ROM,
        S_LOAD,
        S_SETTLE,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [FIELD_W-1:0]      note_q, note_d;
    logic [FIELD_W-1:0]      dur_q, dur_d;
    logic                    load_q, load_d;
    logic                    play_en_q, play_en_d;
    logic                    done_q, done_d;
    // Address already advanced for the next note; waiting for play to fetch it.
    logic                    pending_q, pending_d;
    logic                    run_state;

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            note_q    <= '0;
            dur_q     <= '0;
            load_q    <= 1'b0;
            play_en_q <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            note_q    <= note_d;
            dur_q     <= dur_d;
            load_q    <= load_d;
            play_en_q <= play_en_d;
            done_q    <= done_d;
            pending_q <= pending_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        note_d    = note_q;
        dur_d     = dur_q;
        pending_d = pending_q;
        run_state = (state_q == S_FETCH) || (state_q == S_WAIT_ROM) || (state_q == S_LOAD) ||
                    (state_q == S_SETTLE) || (state_q == S_WAIT_DONE);

        if (restart) begin
            // Restart beats everything, including a coincident done_with_note.
            state_d   = S_IDLE;
            addr_d    = '0;
            pending_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE:     if (play) state_d = S_FETCH;
                S_FETCH:    state_d = S_WAIT_ROM;
                S_WAIT_ROM: begin
                    if (rom_data == 12'h000) begin
                        state_d = S_DONE;
                    end else begin
                        note_d  = rom_data[11:6];
                        dur_d   = rom_data[5:0];
                        state_d = S_LOAD;
                    end
                end
                S_LOAD:     state_d = S_SETTLE;
                // done_with_note may still be stale from the previous note here.
                S_SETTLE:   state_d = S_WAIT_DONE;
                S_WAIT_DONE: begin
                    // Address advances on the done cycle; the fetch itself is taken from
                    // the pending cycle once play is high, so pause and run share one path.
                    if (pending_q) begin
                        if (play) begin
                            pending_d = 1'b0;
                            state_d   = S_FETCH;
                        end
                    end else if (done_with_note) begin
                        if (addr_q == LAST_ADDR) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d    = addr_q + ADDR_WIDTH'(1);
                            pending_d = 1'b1;
                        end
                    end
                end
                S_DONE:     state_d = S_DONE;
                default:    state_d = S_IDLE;
            endcase
        end

        load_d    = (state_d == S_LOAD);
        done_d    = (state_d == S_DONE);
        play_en_d = run_state && play;
    end

    assign rom_addr         = addr_q;
    assign note_to_load     = note_q;
    assign duration_to_load = dur_q;
    assign load_new_note    = load_q;
    assign play_enable      = play_en_q;
    assign song_done        = done_q;

endmodule
